// File: rtl/tri_seq_checker.sv
// Monitor for the up/down triangle-sequence generator: tracks direction,
// flags peak/valley turnarounds, counts periods and illegal steps.
//
//   state | meaning
//   IDLE  | waiting for the first sample to seed prev
//   ACQ   | searching for a +1/-1 step to pick a direction
//   UP    | tracking an ascending run
//   DOWN  | tracking a descending run
//   FAULT | one sample after an illegal step, resyncs like ACQ
module tri_seq_checker #(
    parameter int WIDTH      = 4,
    parameter int LOCK_STEPS = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] seq_in,
    input  logic             clr,
    output logic             locked,
    output logic             dir,
    output logic             peak,
    output logic             valley,
    output logic [CNT_W-1:0] periods,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACQ   = 3'd1,
        S_UP    = 3'd2,
        S_DOWN  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [WIDTH:0]   ONE_E    = 1;
    localparam logic [WIDTH:0]   MAX_E    = {1'b0, {WIDTH{1'b1}}};
    localparam logic [3:0]       LOCK_MAX = 4'(LOCK_STEPS);
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_SAT  = '1;

    state_t           state, state_nx;
    logic [WIDTH-1:0] prev;
    logic [3:0]       lock_cnt, lock_nx, lock_inc;
    logic [WIDTH:0]   p_e, n_e;
    logic             up_step, dn_step;
    logic             peak_ev, valley_ev, err_ev, dir_nx;
    logic             valley_hit, err_hit;

    // Extra bit keeps MAX->0 from looking like a +1 step.
    assign p_e      = {1'b0, prev};
    assign n_e      = {1'b0, seq_in};
    assign up_step  = (n_e == p_e + ONE_E);
    assign dn_step  = (p_e == n_e + ONE_E);
    assign lock_inc = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + 4'd1;

    always_comb begin
        state_nx  = state;
        lock_nx   = lock_cnt;
        peak_ev   = 1'b0;
        valley_ev = 1'b0;
        err_ev    = 1'b0;
        case (state)
            S_IDLE: state_nx = S_ACQ;
            S_ACQ, S_FAULT: begin
                if (up_step) begin
                    state_nx = S_UP;
                    lock_nx  = lock_inc;
                end else if (dn_step) begin
                    state_nx = S_DOWN;
                    lock_nx  = lock_inc;
                end else begin
                    state_nx = S_ACQ;
                    lock_nx  = 4'd0;
                end
            end
            S_UP: begin
                if (up_step) begin
                    lock_nx = lock_inc;
                end else if (p_e == MAX_E && dn_step) begin
                    state_nx = S_DOWN;
                    lock_nx  = lock_inc;
                    peak_ev  = 1'b1;
                end else begin
                    state_nx = S_FAULT;
                    lock_nx  = 4'd0;
                    err_ev   = 1'b1;
                end
            end
            S_DOWN: begin
                if (dn_step) begin
                    lock_nx = lock_inc;
                end else if (prev == '0 && up_step) begin
                    state_nx  = S_UP;
                    lock_nx   = lock_inc;
                    valley_ev = 1'b1;
                end else begin
                    state_nx = S_FAULT;
                    lock_nx  = 4'd0;
                    err_ev   = 1'b1;
                end
            end
            default: begin
                state_nx = S_IDLE;
                lock_nx  = 4'd0;
            end
        endcase
        dir_nx = dir;
        if (state_nx == S_UP)   dir_nx = 1'b0;
        if (state_nx == S_DOWN) dir_nx = 1'b1;
    end

    assign valley_hit = valid & valley_ev;
    assign err_hit    = valid & err_ev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            prev     <= '0;
            lock_cnt <= 4'd0;
            locked   <= 1'b0;
            dir      <= 1'b0;
            peak     <= 1'b0;
            valley   <= 1'b0;
        end else if (valid) begin
            state    <= state_nx;
            prev     <= seq_in;
            lock_cnt <= lock_nx;
            locked   <= (lock_nx == LOCK_MAX) && (state_nx == S_UP || state_nx == S_DOWN);
            dir      <= dir_nx;
            peak     <= peak_ev;
            valley   <= valley_ev;
        end else begin
            peak   <= 1'b0;
            valley <= 1'b0;
        end
    end

    // A clear coinciding with an event leaves that event counted once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            periods    <= '0;
            err_sticky <= 1'b0;
            err_count  <= '0;
        end else begin
            if (clr)
                periods <= valley_hit ? CNT_ONE : '0;
            else if (valley_hit)
                periods <= periods + CNT_ONE;

            if (clr)
                err_sticky <= err_hit;
            else if (err_hit)
                err_sticky <= 1'b1;

            if (clr)
                err_count <= err_hit ? CNT_ONE : '0;
            else if (err_hit && err_count != CNT_SAT)
                err_count <= err_count + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_tri_seq_checker.sv
// Directed bench for tri_seq_checker: a default instance plus a CNT_W=2
// instance sharing the same stimulus for the saturation case.
module tb_tri_seq_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [3:0] seq_in = 4'd0;
    logic       clr = 1'b0;

    logic       locked, dir, peak, valley, err_sticky;
    logic [7:0] periods, err_count;
    logic       locked2, dir2, peak2, valley2, err_sticky2;
    logic [1:0] periods2, err_count2;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    tri_seq_checker #(.WIDTH(4), .LOCK_STEPS(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .valid(valid), .seq_in(seq_in), .clr(clr),
        .locked(locked), .dir(dir), .peak(peak), .valley(valley),
        .periods(periods), .err_sticky(err_sticky), .err_count(err_count)
    );

    tri_seq_checker #(.WIDTH(4), .LOCK_STEPS(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .valid(valid), .seq_in(seq_in), .clr(clr),
        .locked(locked2), .dir(dir2), .peak(peak2), .valley(valley2),
        .periods(periods2), .err_sticky(err_sticky2), .err_count(err_count2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic [3:0] v, input logic vld, input logic c);
        valid  = vld;
        seq_in = v;
        clr    = c;
        @(posedge clk);
        #1;
        valid = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic send(input int v);
        cyc(4'(v), 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic ramp(input int from, input int to);
        if (from <= to) for (int i = from; i <= to; i++) send(i);
        else            for (int i = from; i >= to; i--) send(i);
    endtask

    int         seq_a [23] = '{9,10,11,12,13,14,15,14,13,12,11,10,9,8,7,6,5,4,3,2,1,0,1};
    // {locked, dir, peak, valley} after each sample
    logic [3:0] exp_a [23] = '{4'b0000,4'b0000,4'b0000,4'b0000,4'b1000,4'b1000,4'b1000,
                               4'b1110,4'b1100,4'b1100,4'b1100,4'b1100,4'b1100,4'b1100,
                               4'b1100,4'b1100,4'b1100,4'b1100,4'b1100,4'b1100,4'b1100,
                               4'b1100,4'b1001};

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_outs", {locked, dir, peak, valley, err_sticky}, 0);
        chk("reset_cnts", {periods, err_count}, 0);

        // dense legal run
        for (int i = 0; i < 23; i++) begin
            send(seq_a[i]);
            chk($sformatf("legal[%0d]", i), {locked, dir, peak, valley}, exp_a[i]);
        end
        chk("legal_periods", periods, 1);
        chk("legal_errs", err_count, 0);
        chk("legal_sticky", err_sticky, 0);

        // same run with valid pattern 1,0,0
        do_reset();
        for (int i = 0; i < 23; i++) begin
            send(seq_a[i]);
            chk($sformatf("gap_v[%0d]", i), {locked, dir, peak, valley}, exp_a[i]);
            for (int g = 0; g < 2; g++) begin
                cyc(4'd3, 1'b0, 1'b0);
                chk($sformatf("gap_h[%0d]", i), {locked, dir, peak, valley}, exp_a[i] & 4'b1100);
            end
        end
        chk("gap_periods", periods, 1);
        chk("gap_errs", err_count, 0);

        // 15 -> 0 wrap is illegal, then ACQ ignores the following non-steps
        do_reset();
        ramp(9, 15);
        chk("wrap_prelock", locked, 1);
        send(0);
        chk("wrap_sticky", err_sticky, 1);
        chk("wrap_cnt1", err_count, 1);
        chk("wrap_unlock", locked, 0);
        send(15);
        send(0);
        send(15);
        send(0);
        chk("wrap_cnt_hold", err_count, 1);
        chk("wrap_nolock", locked, 0);
        cyc(4'd0, 1'b0, 1'b1);
        chk("clr_sticky", err_sticky, 0);
        chk("clr_errs", err_count, 0);

        // repeats after lock; dut2 saturates at 3
        do_reset();
        ramp(3, 7);
        chk("sat_lock", locked2, 1);
        send(7);
        chk("sat_e1", err_count2, 1);
        for (int k = 0; k < 4; k++) begin
            send(8 + k);
            send(8 + k);
        end
        chk("sat_cnt2", err_count2, 3);
        chk("sat_sticky2", err_sticky2, 1);
        chk("sat_cnt1", err_count, 5);

        // build periods to 5, then clr on the valley sample
        do_reset();
        send(1);
        send(0);
        send(1);
        chk("per_first", periods, 1);
        for (int k = 0; k < 4; k++) begin
            ramp(2, 15);
            ramp(14, 0);
            send(1);
        end
        chk("per_five", periods, 5);
        ramp(2, 15);
        ramp(14, 0);
        cyc(4'd1, 1'b1, 1'b1);
        chk("clr_valley_per", periods, 1);
        chk("clr_valley_pulse", valley, 1);
        cyc(4'd1, 1'b0, 1'b1);
        chk("clr_alone", periods, 0);
        chk("clr_keeps_lock", locked, 1);

        // asynchronous reset while DOWN at 6
        ramp(2, 9);
        ramp(8, 6);
        chk("pre_rst_dir", dir, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst", {locked, dir, peak, valley, err_sticky, periods, err_count}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        send(3);
        send(4);
        send(5);
        chk("restart_err", {err_sticky, err_count}, 0);
        chk("restart_dir", dir, 0);
        chk("restart_lock", locked, 0);
        send(6);
        send(7);
        chk("restart_locked", locked, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
